// File: rtl/bus_arbiter_pkg.sv
// Shared bus widths and FSM encoding for the fetch/data bus arbiter.
package bus_arbiter_pkg;

    localparam int RegBus      = 32;
    localparam int InstAddrBus = 32;
    localparam int SelBus      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_timer.sv
// Grant wait counter: runs while a grant is outstanding and flags a timeout
// when the slave has not acknowledged within TIMEOUT cycles.
module arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic bus_ack,
    output logic expired
);

    localparam int CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

    logic [CntW-1:0] count_reg;

    // An ack in the limit cycle wins over the timeout.
    assign expired = busy && !bus_ack && (count_reg == Limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (!busy) begin
            count_reg <= '0;
        end else if (!bus_ack && (count_reg != Limit)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: data port has priority, fetch port is protected
// from starvation, registered bus outputs and a timeout on silent slaves.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req_i,
    input  logic [InstAddrBus-1:0] if_addr_i,
    output logic [RegBus-1:0]      if_rdata_o,
    output logic                   if_ack_o,
    input  logic                   mem_req_i,
    input  logic                   mem_we_i,
    input  logic [RegBus-1:0]      mem_addr_i,
    input  logic [RegBus-1:0]      mem_wdata_i,
    input  logic [SelBus-1:0]      mem_sel_i,
    output logic [RegBus-1:0]      mem_rdata_o,
    output logic                   mem_ack_o,
    output logic                   bus_ce_o,
    output logic                   bus_we_o,
    output logic [RegBus-1:0]      bus_addr_o,
    output logic [RegBus-1:0]      bus_wdata_o,
    output logic [SelBus-1:0]      bus_sel_o,
    input  logic [RegBus-1:0]      bus_rdata_i,
    input  logic                   bus_ack_i,
    output logic                   stall_o,
    output logic                   err_o
);

    localparam int StreakW = $clog2(STARVE_LIMIT + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);

    arb_state_e          state_reg, state_next;
    logic [StreakW-1:0]  streak_reg, streak_next;
    logic                bus_ce_reg, bus_ce_next;
    logic                bus_we_reg, bus_we_next;
    logic [RegBus-1:0]   bus_addr_reg, bus_addr_next;
    logic [RegBus-1:0]   bus_wdata_reg, bus_wdata_next;
    logic [SelBus-1:0]   bus_sel_reg, bus_sel_next;
    logic                if_ack_reg, if_ack_next;
    logic                mem_ack_reg, mem_ack_next;
    logic [RegBus-1:0]   if_rdata_reg, if_rdata_next;
    logic [RegBus-1:0]   mem_rdata_reg, mem_rdata_next;
    logic                err_reg, err_next;
    logic                busy, expired, done, ack_cycle;

    assign busy      = (state_reg != IDLE);
    assign ack_cycle = if_ack_reg | mem_ack_reg;
    assign done      = busy & (bus_ack_i | expired);

    arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .bus_ack (bus_ack_i),
        .expired (expired)
    );

    always_comb begin
        state_next     = state_reg;
        streak_next    = streak_reg;
        bus_ce_next    = bus_ce_reg;
        bus_we_next    = bus_we_reg;
        bus_addr_next  = bus_addr_reg;
        bus_wdata_next = bus_wdata_reg;
        bus_sel_next   = bus_sel_reg;
        if_rdata_next  = if_rdata_reg;
        mem_rdata_next = mem_rdata_reg;
        if_ack_next    = 1'b0;
        mem_ack_next   = 1'b0;
        err_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                // The completion cycle grants nothing: the finished requester's
                // req is stale and both sides re-arbitrate together next cycle.
                if (!ack_cycle && if_req_i && (!mem_req_i || (streak_reg == StreakMax))) begin
                    state_next    = GNT_IF;
                    streak_next   = '0;
                    bus_ce_next   = 1'b1;
                    bus_we_next   = 1'b0;
                    bus_addr_next = if_addr_i;
                    bus_sel_next  = 4'hF;
                end else if (!ack_cycle && mem_req_i) begin
                    state_next     = GNT_MEM;
                    bus_ce_next    = 1'b1;
                    bus_we_next    = mem_we_i;
                    bus_addr_next  = mem_addr_i;
                    bus_wdata_next = mem_wdata_i;
                    bus_sel_next   = mem_sel_i;
                    if (if_req_i && (streak_reg != StreakMax)) begin
                        streak_next = streak_reg + 1'b1;
                    end
                end
            end
            GNT_IF, GNT_MEM: begin
                if (done) begin
                    state_next  = IDLE;
                    bus_ce_next = 1'b0;
                    bus_we_next = 1'b0;
                    err_next    = ~bus_ack_i;
                    if (state_reg == GNT_IF) begin
                        if_ack_next   = 1'b1;
                        if_rdata_next = bus_ack_i ? bus_rdata_i : '0;
                    end else begin
                        mem_ack_next   = 1'b1;
                        mem_rdata_next = bus_ack_i ? bus_rdata_i : '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            streak_reg    <= '0;
            bus_ce_reg    <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            bus_sel_reg   <= '0;
            if_ack_reg    <= 1'b0;
            mem_ack_reg   <= 1'b0;
            if_rdata_reg  <= '0;
            mem_rdata_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            streak_reg    <= streak_next;
            bus_ce_reg    <= bus_ce_next;
            bus_we_reg    <= bus_we_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            bus_sel_reg   <= bus_sel_next;
            if_ack_reg    <= if_ack_next;
            mem_ack_reg   <= mem_ack_next;
            if_rdata_reg  <= if_rdata_next;
            mem_rdata_reg <= mem_rdata_next;
            err_reg       <= err_next;
        end
    end

    assign bus_ce_o    = bus_ce_reg;
    assign bus_we_o    = bus_we_reg;
    assign bus_addr_o  = bus_addr_reg;
    assign bus_wdata_o = bus_wdata_reg;
    assign bus_sel_o   = bus_sel_reg;
    assign if_ack_o    = if_ack_reg;
    assign mem_ack_o   = mem_ack_reg;
    assign if_rdata_o  = if_rdata_reg;
    assign mem_rdata_o = mem_rdata_reg;
    assign err_o       = err_reg;
    assign stall_o     = (if_req_i & ~if_ack_reg) | (mem_req_i & ~mem_ack_reg);

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected bus grants and acks are queued
// as requests are driven and compared when the arbiter produces them.
module tb_bus_arbiter;

    localparam logic [31:0] KEY = 32'h2401_0015;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } bus_txn_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } ack_txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        bus_ce_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        stall_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_ce_cyc = 0;
    int ack_delay = 0;
    bit ack_en = 1'b1;
    bit idle_ack = 1'b0;

    bus_txn_t grant_q[$];
    ack_txn_t if_q[$];
    ack_txn_t mem_q[$];

    bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_sel_i   (mem_sel_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_ack_o   (mem_ack_o),
        .bus_ce_o    (bus_ce_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_sel_o   (bus_sel_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits from the next falling edge for the chosen ack; returns its cycle.
    task automatic wait_ack(input bit is_if, input int limit, output int at_cyc);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        at_cyc = -1;
        while (!done) begin
            @(negedge clk);
            n++;
            if ((is_if ? if_ack_o : mem_ack_o) == 1'b1) begin
                at_cyc = cyc;
                done = 1'b1;
            end else if (n >= limit) begin
                check(is_if ? "if_ack_wait" : "mem_ack_wait",
                      32'(is_if ? if_ack_o : mem_ack_o), 32'd1);
                done = 1'b1;
            end
        end
    endtask

    // Bus slave: acks after ack_delay ce cycles, read data derived from address.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus_ack_i = 1'b0;
        bus_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (idle_ack) begin
                bus_ack_i = 1'b1;
                bus_rdata_i = 32'hBAD0_0000;
            end else if (bus_ce_o && ack_en) begin
                if (wait_cnt >= ack_delay) begin
                    bus_ack_i = 1'b1;
                    bus_rdata_i = bus_addr_o ^ KEY;
                    wait_cnt = 0;
                end else begin
                    bus_ack_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus_ack_i = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: compares each new bus cycle and each ack against the queues.
    initial begin
        bus_txn_t g;
        ack_txn_t a;
        logic ce_prev;
        ce_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_ce_o && !ce_prev) begin
                last_ce_cyc = cyc;
                if (grant_q.size() == 0) begin
                    check("spurious_grant", 32'(bus_ce_o), 32'd0);
                end else begin
                    g = grant_q.pop_front();
                    check("bus_we", 32'(bus_we_o), 32'(g.we));
                    check("bus_addr", bus_addr_o, g.addr);
                    check("bus_sel", 32'(bus_sel_o), 32'(g.sel));
                    if (g.we) check("bus_wdata", bus_wdata_o, g.wdata);
                end
            end
            ce_prev = bus_ce_o;
            if (if_ack_o) begin
                if (if_q.size() == 0) begin
                    check("spurious_if_ack", 32'(if_ack_o), 32'd0);
                end else begin
                    a = if_q.pop_front();
                    check("if_rdata", if_rdata_o, a.rdata);
                    check("if_err", 32'(err_o), 32'(a.err));
                    check("if_ack_ce_low", 32'(bus_ce_o), 32'd0);
                end
                $display("txn fetch rdata=%h err=%0b cyc=%0d", if_rdata_o, err_o, cyc);
            end
            if (mem_ack_o) begin
                if (mem_q.size() == 0) begin
                    check("spurious_mem_ack", 32'(mem_ack_o), 32'd0);
                end else begin
                    a = mem_q.pop_front();
                    check("mem_rdata", mem_rdata_o, a.rdata);
                    check("mem_err", 32'(err_o), 32'(a.err));
                    check("mem_ack_ce_low", 32'(bus_ce_o), 32'd0);
                end
                $display("txn data rdata=%h err=%0b cyc=%0d", mem_rdata_o, err_o, cyc);
            end
            if (err_o && !if_ack_o && !mem_ack_o) check("err_without_ack", 32'(err_o), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1;
        rst = 1'b0;
        if_req_i = 1'b0;
        if_addr_i = '0;
        mem_req_i = 1'b0;
        mem_we_i = 1'b0;
        mem_addr_i = '0;
        mem_wdata_i = '0;
        mem_sel_i = '0;
        idle(3);
        check("rst_ce", 32'(bus_ce_o), 32'd0);
        check("rst_we", 32'(bus_we_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_if_ack", 32'(if_ack_o), 32'd0);
        check("rst_mem_ack", 32'(mem_ack_o), 32'd0);
        check("rst_addr", bus_addr_o, 32'd0);
        check("rst_sel", 32'(bus_sel_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        rst = 1'b1;
        idle(2);

        // Single fetch at minimum latency.
        if_addr_i = 32'h0000_0010;
        if_req_i = 1'b1;
        grant_q.push_back('{we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0, sel: 4'hF});
        if_q.push_back('{rdata: 32'h2401_0005, err: 1'b0});
        t0 = cyc;
        wait_ack(1'b1, 20, t1);
        check("t030_latency", 32'(t1 - t0), 32'd2);
        if_req_i = 1'b0;

        // Simultaneous requests: data first, then fetch.
        idle(2);
        if_addr_i = 32'h0000_0020;
        mem_we_i = 1'b1;
        mem_addr_i = 32'h0000_0100;
        mem_wdata_i = 32'hDEAD_BEEF;
        mem_sel_i = 4'b0011;
        if_req_i = 1'b1;
        mem_req_i = 1'b1;
        grant_q.push_back('{we: 1'b1, addr: 32'h0000_0100, wdata: 32'hDEAD_BEEF, sel: 4'b0011});
        grant_q.push_back('{we: 1'b0, addr: 32'h0000_0020, wdata: 32'h0, sel: 4'hF});
        mem_q.push_back('{rdata: 32'h0000_0100 ^ KEY, err: 1'b0});
        if_q.push_back('{rdata: 32'h0000_0020 ^ KEY, err: 1'b0});
        idle(1);
        check("t031_stall_both", 32'(stall_o), 32'd1);
        wait_ack(1'b0, 20, t1);
        check("t031_stall_mem_ack", 32'(stall_o), 32'd1);
        mem_req_i = 1'b0;
        mem_we_i = 1'b0;
        wait_ack(1'b1, 20, t1);
        check("t031_stall_if_ack", 32'(stall_o), 32'd0);
        if_req_i = 1'b0;
        idle(1);
        check("t031_mem_rdata_hold", mem_rdata_o, 32'h0000_0100 ^ KEY);

        // Continuous traffic on both ports: four data grants, then one fetch.
        idle(2);
        if_addr_i = 32'h0000_0040;
        mem_addr_i = 32'h0000_0200;
        mem_sel_i = 4'hF;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                grant_q.push_back('{we: 1'b0, addr: 32'h0000_0200, wdata: 32'h0, sel: 4'hF});
                mem_q.push_back('{rdata: 32'h0000_0200 ^ KEY, err: 1'b0});
            end
            grant_q.push_back('{we: 1'b0, addr: 32'h0000_0040, wdata: 32'h0, sel: 4'hF});
            if_q.push_back('{rdata: 32'h0000_0040 ^ KEY, err: 1'b0});
        end
        if_req_i = 1'b1;
        mem_req_i = 1'b1;
        wait_ack(1'b1, 40, t1);
        wait_ack(1'b1, 40, t1);
        if_req_i = 1'b0;
        mem_req_i = 1'b0;
        idle(3);
        check("t032_grants_left", 32'(grant_q.size()), 32'd0);
        check("t032_mem_left", 32'(mem_q.size()), 32'd0);

        // Req held through its ack cycle only: one transaction.
        idle(2);
        mem_addr_i = 32'h0000_0300;
        mem_sel_i = 4'b1100;
        mem_req_i = 1'b1;
        grant_q.push_back('{we: 1'b0, addr: 32'h0000_0300, wdata: 32'h0, sel: 4'b1100});
        mem_q.push_back('{rdata: 32'h0000_0300 ^ KEY, err: 1'b0});
        wait_ack(1'b0, 20, t1);
        check("t035_stall_at_ack", 32'(stall_o), 32'd0);
        idle(1);
        mem_req_i = 1'b0;
        idle(4);
        check("t035_single_txn", 32'(grant_q.size() + mem_q.size()), 32'd0);

        // Req still high after ack+1: a second transaction follows.
        mem_req_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            grant_q.push_back('{we: 1'b0, addr: 32'h0000_0300, wdata: 32'h0, sel: 4'b1100});
            mem_q.push_back('{rdata: 32'h0000_0300 ^ KEY, err: 1'b0});
        end
        wait_ack(1'b0, 20, t1);
        wait_ack(1'b0, 20, t1);
        mem_req_i = 1'b0;
        idle(3);
        check("t035_two_txn", 32'(grant_q.size() + mem_q.size()), 32'd0);

        // Ack in the very cycle the wait count hits TIMEOUT is a normal ack.
        ack_delay = 255;
        if_addr_i = 32'h0000_0050;
        if_req_i = 1'b1;
        grant_q.push_back('{we: 1'b0, addr: 32'h0000_0050, wdata: 32'h0, sel: 4'hF});
        if_q.push_back('{rdata: 32'h0000_0050 ^ KEY, err: 1'b0});
        t0 = cyc;
        wait_ack(1'b1, 300, t1);
        if_req_i = 1'b0;
        check("t023_latency", 32'(t1 - t0), 32'd257);
        ack_delay = 0;

        // Slave ack while idle is ignored and read data holds.
        idle(2);
        idle_ack = 1'b1;
        idle(4);
        idle_ack = 1'b0;
        check("t022_ce_idle", 32'(bus_ce_o), 32'd0);
        check("t022_if_rdata_hold", if_rdata_o, 32'h0000_0050 ^ KEY);

        // Silent slave: timeout ack with error 256 cycles after ce rises.
        idle(2);
        ack_en = 1'b0;
        mem_we_i = 1'b1;
        mem_addr_i = 32'h0000_0400;
        mem_wdata_i = 32'h1234_5678;
        mem_sel_i = 4'hF;
        mem_req_i = 1'b1;
        grant_q.push_back('{we: 1'b1, addr: 32'h0000_0400, wdata: 32'h1234_5678, sel: 4'hF});
        mem_q.push_back('{rdata: 32'h0, err: 1'b1});
        wait_ack(1'b0, 300, t1);
        check("t033_latency", 32'(t1 - last_ce_cyc), 32'd256);
        mem_req_i = 1'b0;
        mem_we_i = 1'b0;
        ack_en = 1'b1;
        idle(1);
        check("t033_err_one_cycle", 32'(err_o), 32'd0);
        check("t033_ce_idle", 32'(bus_ce_o), 32'd0);

        // Reset during a data grant abandons it; a fresh request then completes.
        idle(2);
        ack_en = 1'b0;
        mem_addr_i = 32'h0000_0500;
        mem_req_i = 1'b1;
        grant_q.push_back('{we: 1'b0, addr: 32'h0000_0500, wdata: 32'h0, sel: 4'hF});
        idle(3);
        check("t034_ce_before", 32'(bus_ce_o), 32'd1);
        check("t034_addr_before", bus_addr_o, 32'h0000_0500);
        rst = 1'b0;
        mem_req_i = 1'b0;
        #1;
        check("t034_ce", 32'(bus_ce_o), 32'd0);
        check("t034_addr", bus_addr_o, 32'd0);
        check("t034_wdata", bus_wdata_o, 32'd0);
        check("t034_sel", 32'(bus_sel_o), 32'd0);
        check("t034_mem_ack", 32'(mem_ack_o), 32'd0);
        check("t034_if_rdata", if_rdata_o, 32'd0);
        idle(3);
        rst = 1'b1;
        ack_en = 1'b1;
        idle(2);
        mem_req_i = 1'b1;
        grant_q.push_back('{we: 1'b0, addr: 32'h0000_0500, wdata: 32'h0, sel: 4'hF});
        mem_q.push_back('{rdata: 32'h0000_0500 ^ KEY, err: 1'b0});
        wait_ack(1'b0, 20, t1);
        mem_req_i = 1'b0;
        idle(3);

        check("end_grants_left", 32'(grant_q.size()), 32'd0);
        check("end_if_left", 32'(if_q.size()), 32'd0);
        check("end_mem_left", 32'(mem_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch is pending.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles a grant waits for bus_ack_i.
REQ-003 SHALL have ports clk, in, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, in, 1, asynchronous, active-low reset.
REQ-005 SHALL have fetch-side ports: if_req_i in 1; if_addr_i in 32; if_rdata_o out 32; if_ack_o out 1.
REQ-006 SHALL have data-side ports: mem_req_i in 1; mem_we_i in 1; mem_addr_i in 32; mem_wdata_i in 32; mem_sel_i in 4; mem_rdata_o out 32; mem_ack_o out 1.
REQ-007 SHALL have bus-side ports: bus_ce_o out 1; bus_we_o out 1; bus_addr_o out 32; bus_wdata_o out 32; bus_sel_o out 4; bus_rdata_i in 32; bus_ack_i in 1.
REQ-008 SHALL have status ports: stall_o out 1, pipeline hold request; err_o out 1, one-cycle timeout pulse.

Function
REQ-009 SHALL implement an FSM with states IDLE, GNT_IF and GNT_MEM.
REQ-010 Requesters SHALL hold req and all request fields stable until their ack; the arbiter does not latch them.
REQ-011 SHALL arbitrate in IDLE, with data priority: mem_req_i goes to GNT_MEM; otherwise if_req_i goes to GNT_IF; otherwise stay IDLE.
REQ-012 Starvation override: when streak counter == STARVE_LIMIT and if_req_i is high, SHALL choose GNT_IF even if mem_req_i is high.
REQ-013 Streak counter SHALL increment on each data grant made while if_req_i is high, saturate at STARVE_LIMIT, and clear on every fetch grant.
REQ-014 Bus outputs SHALL be registered and SHALL change in the cycle after arbitration (request in IDLE at cycle n, bus_ce_o high at n+1).
REQ-015 GNT_IF SHALL drive bus_we_o=0, bus_sel_o=4'hF and bus_addr_o=if_addr_i.
REQ-016 GNT_MEM SHALL pass through mem_we_i, mem_addr_i, mem_wdata_i and mem_sel_i.
REQ-017 bus_ack_i sampled high in a grant state at cycle m SHALL cause all of the following at m+1:
  - granted ack_o high for exactly one cycle;
  - granted rdata_o = bus_rdata_i captured at m;
  - state IDLE and bus_ce_o low.
REQ-018 In the IDLE cycle where an ack_o is high, that requester's req SHALL be masked from arbitration, preventing a duplicate transaction.
REQ-019 Minimum request-to-ack latency SHALL be 2 cycles, reached when bus_ack_i is high on the first bus_ce_o cycle.
REQ-020 A wait counter SHALL clear on grant entry and increment each grant cycle without bus_ack_i.
REQ-021 On wait counter reaching TIMEOUT, SHALL at the next cycle:
  - return to IDLE;
  - pulse the granted ack_o with rdata_o=0;
  - pulse err_o.
REQ-022 bus_ack_i in IDLE SHALL be ignored.
REQ-023 bus_ack_i in the same cycle the wait counter reaches TIMEOUT SHALL count as a normal ack, with no err_o.
REQ-024 stall_o SHALL be combinational: (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o).
REQ-025 rdata_o outputs SHALL hold their last captured value between acks.

Reset
REQ-026 rst low SHALL asynchronously force:
  - state IDLE and both counters 0;
  - all ack, ce, we and err outputs 0;
  - all address, data and sel outputs 0.
REQ-027 Reset mid-transaction SHALL abandon the bus cycle with no ack; requesters reissue after reset.

Structure
REQ-028 FSM state encodings and bus widths (RegBus, InstAddrBus) SHALL live in the shared define include, not locally.
REQ-029 The wait/timeout counter MAY be a sub-module named arb_timer; the streak counter stays inline.

Verification
REQ-030 Single fetch, if_addr_i=32'h0000_0010, bus_ack_i at the first ce cycle with rdata 32'h2401_0005 -> if_ack_o at cycle 2, if_rdata_o=32'h2401_0005, bus_we_o=0.
REQ-031 if_req_i and mem_req_i (write, addr 32'h0000_0100, data 32'hDEAD_BEEF, sel 4'b0011) raised together -> data granted first, then fetch; stall_o high until each ack.
REQ-032 Continuous mem_req_i with continuous if_req_i -> exactly 4 data grants, then 1 fetch grant, repeating.
REQ-033 Grant with bus_ack_i never asserted -> ack_o and err_o pulse 256 cycles after ce rises, rdata_o=0, FSM in IDLE.
REQ-034 rst low during GNT_MEM with bus_ce_o high -> all outputs 0 immediately, no mem_ack_o; after release, a fresh request completes normally.
REQ-035 Requester holds req through its ack cycle -> exactly one bus transaction; a second starts only if req is still high at ack+1.
